or3_response_checker: RTL
=========================

OR3_RESPONSE_CHECKER -- requirements
Module: or3_response_checker

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the vector and fail counters.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begin a check run (IDLE or DONE only).
REQ-005 SHALL have port abort, input, 1: terminate a run in progress (RUN only).
REQ-006 SHALL have port valid, input, 1: a, b, c, y hold one observed sample this cycle.
REQ-007 SHALL have ports a, b, c, input, 1 each: applied DUT inputs.
REQ-008 SHALL have port y, input, 1: observed DUT output.
REQ-009 SHALL have port busy, output, 1: high in RUN.
REQ-010 SHALL have port done, output, 1: high in DONE.
REQ-011 SHALL have port pass, output, 1: high in DONE when fail_cnt == 0.
REQ-012 SHALL have port vec_cnt, output, CNT_W: accepted samples this run.
REQ-013 SHALL have port fail_cnt, output, CNT_W: mismatching samples this run.
REQ-014 SHALL have port coverage, output, 8: bit {a,b,c} set once that input vector has been seen.

Function
REQ-015 SHALL implement the FSM IDLE -> RUN (start) -> DONE (coverage full), DONE -> RUN (start), RUN -> IDLE (abort).
REQ-016 SHALL clear vec_cnt, fail_cnt and coverage on the edge that enters RUN.
REQ-017 SHALL, for each valid sample in RUN, compute expected = a|b|c and increment fail_cnt when y != expected.
REQ-018 SHALL, for each valid sample in RUN, increment vec_cnt and set coverage[{a,b,c}].
REQ-019 SHALL make counter and coverage updates visible on the cycle after the sample (latency 1).
REQ-020 SHALL saturate vec_cnt and fail_cnt at 2^CNT_W-1; there is no wrap-around.
REQ-021 SHALL enter DONE on the same edge that sets the last coverage bit, so done rises one cycle after the completing sample.
REQ-022 SHALL ignore valid in IDLE and DONE; counters and coverage hold their values.
REQ-023 SHALL ignore start in RUN and abort outside RUN; when start and abort are asserted together in RUN, abort wins.
REQ-024 SHALL, on abort, hold vec_cnt, fail_cnt and coverage for inspection; done and pass stay 0.
REQ-025 SHALL still process a valid sample that coincides with abort before returning to IDLE.
REQ-026 SHALL accept repeated vectors: they count toward vec_cnt and fail_cnt but do not change coverage.

Reset
REQ-027 SHALL, when rst is high at a clock edge, go to IDLE with busy=0, done=0, pass=0, vec_cnt=0, fail_cnt=0, coverage=0 (and first-fail registers 0); rst overrides start, abort and valid.
REQ-028 SHALL discard an in-progress run when rst is asserted mid-run, with no partial result retained.

Configuration
REQ-029 SHALL use macro OR3_FIRST_FAIL_CAPTURE_EN to compile in this feature.
REQ-030 SHALL, with the macro defined, add outputs first_fail_vec (3 bits, {a,b,c}), first_fail_y (1 bit) and first_fail_idx (CNT_W bits, vec_cnt value at that sample), latched on the first mismatch of a run and cleared on run start.
REQ-031 SHALL, without the macro, omit these outputs and their registers entirely; all other behaviour is identical.

Structure
REQ-032 SHALL place the FSM state encoding (IDLE, RUN, DONE) and the constant COV_FULL = 8'hFF in shared package or3_check_pkg.
REQ-033 SHALL use one sub-module, or3_ref_model: a combinational expected = a|b|c golden model, instantiated once.

Verification
REQ-034 SHALL test: rst, start, then 8 exhaustive vectors 000..111, one per cycle, with correct y -> done=1 one cycle after vector 111, pass=1, vec_cnt=8, fail_cnt=0, coverage=8'hFF.
REQ-035 SHALL test: the same sequence with y=0 forced at vector 101 -> fail_cnt=1, pass=0; with the macro defined, first_fail_vec=3'b101, first_fail_y=0, first_fail_idx=5.
REQ-036 SHALL test: 6 distinct vectors, then abort -> IDLE, busy=0, done=0, vec_cnt=6, coverage holds 6 bits; valid pulses afterwards leave all outputs unchanged.
REQ-037 SHALL test: with CNT_W=2, vector 000 sent 5 times, then the remaining 7 vectors all with bad y -> vec_cnt=3 and fail_cnt=3 (saturated), done=1, pass=0.
REQ-038 SHALL test: rst asserted after 4 samples -> next cycle all outputs 0 and IDLE; start then begins a clean run.
REQ-039 SHALL test: start in DONE -> RUN, counters cleared, done=0 on the following cycle.

Source files
------------

// File: rtl/or3_check_pkg.sv
// ---------------------------------------------------------------------------
// or3_check_pkg
// Shared definitions for the OR3 response checker.
//   state_e  : checker FSM encoding (IDLE, RUN, DONE)
//   COV_FULL : coverage value meaning all eight {a,b,c} vectors were seen
// ---------------------------------------------------------------------------
package or3_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] COV_FULL = 8'hFF;

    // One-hot coverage bit for an input vector {a,b,c}.
    function automatic logic [7:0] cov_bit(input logic [2:0] vec);
        cov_bit = 8'b0000_0001 << vec;
    endfunction

endpackage

// File: rtl/or3_ref_model.sv
// ---------------------------------------------------------------------------
// or3_ref_model
// Combinational golden model of the device under check: expected = a|b|c.
// Ports:
//   a, b, c  : applied inputs
//   expected : reference output
// ---------------------------------------------------------------------------
module or3_ref_model (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic expected
);

    assign expected = a | b | c;

endmodule

// File: rtl/or3_response_checker.sv
// ---------------------------------------------------------------------------
// or3_response_checker
// Observes samples of an OR3 device (inputs a,b,c and output y) and scores
// them against a golden model. A run starts with `start`, ends in DONE once
// all eight input vectors have been seen, or returns to IDLE on `abort`.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : run control
//   valid, a, b, c  : one observed sample (inputs applied to the device)
//   y               : observed device output
//   busy, done      : FSM in RUN / in DONE
//   pass            : DONE with no mismatches
//   vec_cnt         : accepted samples this run (saturating)
//   fail_cnt        : mismatching samples this run (saturating)
//   coverage        : bit {a,b,c} set once that vector has been seen
//
// Optional feature, compiled in with `define OR3_FIRST_FAIL_CAPTURE_EN:
//   first_fail_vec  : {a,b,c} of the first mismatch of the run
//   first_fail_y    : observed y at that mismatch
//   first_fail_idx  : vec_cnt value at that mismatch
// ---------------------------------------------------------------------------
module or3_response_checker
    import or3_check_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             y,
`ifdef OR3_FIRST_FAIL_CAPTURE_EN
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_y,
    output logic [CNT_W-1:0] first_fail_idx,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [7:0]       coverage
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_e     state_q, state_d;
    logic       expected;
    logic       sample_ok;
    logic       mismatch;
    logic       enter_run;
    logic [7:0] cov_next;

    or3_ref_model u_ref (
        .a        (a),
        .b        (b),
        .c        (c),
        .expected (expected)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        sample_ok = 1'b0;
        enter_run = 1'b0;
        mismatch  = 1'b0;
        cov_next  = coverage;
        state_d   = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                sample_ok = valid;
                mismatch  = valid && (y != expected);
                if (valid) cov_next = coverage | cov_bit({a, b, c});
                // Abort wins over completion; the coincident sample is
                // still scored by the datapath below.
                if (abort)                      state_d = IDLE;
                else if (cov_next == COV_FULL)  state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d   = RUN;
                    enter_run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and coverage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || enter_run) begin
            vec_cnt  <= '0;
            fail_cnt <= '0;
            coverage <= '0;
        end else if (sample_ok) begin
            vec_cnt  <= sat_inc(vec_cnt);
            coverage <= cov_next;
            if (mismatch) fail_cnt <= sat_inc(fail_cnt);
        end
    end

`ifdef OR3_FIRST_FAIL_CAPTURE_EN
    // fail_cnt only leaves zero on a mismatch and never wraps, so zero
    // identifies the first mismatch of the run.
    always_ff @(posedge clk) begin
        if (rst || enter_run) begin
            first_fail_vec <= '0;
            first_fail_y   <= 1'b0;
            first_fail_idx <= '0;
        end else if (mismatch && (fail_cnt == '0)) begin
            first_fail_vec <= {a, b, c};
            first_fail_y   <= y;
            first_fail_idx <= vec_cnt;
        end
    end
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign pass = done && (fail_cnt == '0);

endmodule
